// File: rtl/write_buffer_if.sv
// Cache-side and DRAM-side signals of the write buffer.
// The cache/DRAM model drives through master; the buffer uses slave.
interface write_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_req;
  logic [29:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic [27:0]   rd_addr;
  logic          rd_valid;
  logic [127:0]  rd_data;
  logic          mem_we;
  logic          mem_re;
  logic [27:0]   mem_addr;
  logic [1:0]    mem_offset;
  logic [31:0]   mem_din;
  logic [127:0]  mem_dout;
  logic          mem_complete;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout, mem_complete,
    input  wr_ready, rd_valid, rd_data, mem_we, mem_re, mem_addr, mem_offset,
           mem_din, count, empty
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout, mem_complete,
    output wr_ready, rd_valid, rd_data, mem_we, mem_re, mem_addr, mem_offset,
           mem_din, count, empty
  );
endinterface

// File: rtl/write_buffer.sv
// Word write buffer between cache and DRAM: FIFO of pending writes drained
// one word at a time; line fills are served only once the buffer is empty.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  write_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count_q;
  logic [29:0]   addr_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          push, pop, capture;

  logic          mem_we_q, mem_re_q, mem_we_n, mem_re_n;
  logic [27:0]   mem_addr_q, mem_addr_n;
  logic [1:0]    mem_offset_q, mem_offset_n;
  logic [31:0]   mem_din_q, mem_din_n;
  logic [127:0]  rd_data_q;

  assign bus.wr_ready   = (count_q != FULL);
  assign bus.count      = count_q;
  assign bus.empty      = (count_q == '0);
  assign bus.rd_valid   = (state == RDONE);
  assign bus.rd_data    = rd_data_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_offset = mem_offset_q;
  assign bus.mem_din    = mem_din_q;

  assign push = bus.wr_req && (count_q != FULL);
  assign pop  = (state == WR) && bus.mem_complete;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= bus.wr_addr;
      data_mem[tail] <= bus.wr_data;
    end
  end

  // Pointers are AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_offset_q <= '0;
      mem_din_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      state        <= state_n;
      mem_we_q     <= mem_we_n;
      mem_re_q     <= mem_re_n;
      mem_addr_q   <= mem_addr_n;
      mem_offset_q <= mem_offset_n;
      mem_din_q    <= mem_din_n;
      if (capture) rd_data_q <= bus.mem_dout;
    end
  end

  // DRAM strobes are computed one cycle ahead so they leave from registers;
  // every operation returns through IDLE, giving the mandatory gap.
  always_comb begin
    state_n      = state;
    mem_we_n     = mem_we_q;
    mem_re_n     = mem_re_q;
    mem_addr_n   = mem_addr_q;
    mem_offset_n = mem_offset_q;
    mem_din_n    = mem_din_q;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        if (count_q != '0) begin
          state_n      = WR;
          mem_we_n     = 1'b1;
          mem_addr_n   = addr_mem[head][29:2];
          mem_offset_n = addr_mem[head][1:0];
          mem_din_n    = data_mem[head];
        end else if (bus.rd_req) begin
          state_n    = RD;
          mem_re_n   = 1'b1;
          mem_addr_n = bus.rd_addr;
        end
      end
      WR: begin
        if (bus.mem_complete) begin
          state_n  = IDLE;
          mem_we_n = 1'b0;
        end
      end
      RD: begin
        if (bus.mem_complete) begin
          state_n  = RDONE;
          mem_re_n = 1'b0;
          capture  = 1'b1;
        end
      end
      RDONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer (DEPTH=4): inputs change on the falling
// edge, outputs are checked on the falling edge.
module tb_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  write_buffer_if #(.DEPTH(4)) bus();
  write_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count"},    128'(bus.count), 128'd0);
    check({tag, "_wr_ready"}, 128'(bus.wr_ready), 128'd1);
    check({tag, "_empty"},    128'(bus.empty), 128'd1);
    check({tag, "_rd_valid"}, 128'(bus.rd_valid), 128'd0);
    check({tag, "_rd_data"},  bus.rd_data, 128'd0);
    check({tag, "_mem_we"},   128'(bus.mem_we), 128'd0);
    check({tag, "_mem_re"},   128'(bus.mem_re), 128'd0);
    check({tag, "_mem_addr"}, 128'(bus.mem_addr), 128'd0);
    check({tag, "_mem_off"},  128'(bus.mem_offset), 128'd0);
    check({tag, "_mem_din"},  128'(bus.mem_din), 128'd0);
  endtask

  task automatic push(input logic [29:0] a, input logic [31:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_req  = 1'b0;
  endtask

  // Waits (bounded) for a DRAM write, checks it, then completes it.
  task automatic expect_write(input string tag, input logic [29:0] a, input logic [31:0] d);
    int t = 0;
    while (!bus.mem_we && t < 20) begin
      check({tag, "_no_re_wait"}, 128'(bus.mem_re), 128'd0);
      step();
      t++;
    end
    check({tag, "_we"},   128'(bus.mem_we), 128'd1);
    check({tag, "_re"},   128'(bus.mem_re), 128'd0);
    check({tag, "_addr"}, 128'(bus.mem_addr), 128'(a[29:2]));
    check({tag, "_off"},  128'(bus.mem_offset), 128'(a[1:0]));
    check({tag, "_din"},  128'(bus.mem_din), 128'(d));
    bus.mem_complete = 1'b1;
    step();
    bus.mem_complete = 1'b0;
    check({tag, "_we_drop"}, 128'(bus.mem_we), 128'd0);
  endtask

  initial begin
    logic [29:0]  wa;
    logic [31:0]  wd;
    logic [127:0] line;
    int           t;

    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.mem_dout = '0; bus.mem_complete = 1'b0;

    step(); step();
    check_reset("rst");
    rst = 1'b0;
    step();
    check_reset("post_rst");

    // Single write, completed three cycles after the strobe appears
    push(30'h0000_0041, 32'hDEAD_BEEF);
    check("s1_count1", 128'(bus.count), 128'd1);
    check("s1_empty0", 128'(bus.empty), 128'd0);
    check("s1_we_late", 128'(bus.mem_we), 128'd0);
    step();
    check("s1_we", 128'(bus.mem_we), 128'd1);
    check("s1_addr", 128'(bus.mem_addr), 128'h10);
    check("s1_off", 128'(bus.mem_offset), 128'd1);
    check("s1_din", 128'(bus.mem_din), 128'hDEAD_BEEF);
    step(); step();
    check("s1_hold_we", 128'(bus.mem_we), 128'd1);
    check("s1_hold_count", 128'(bus.count), 128'd1);
    bus.mem_complete = 1'b1;
    step();
    bus.mem_complete = 1'b0;
    check("s1_count0", 128'(bus.count), 128'd0);
    check("s1_we_drop", 128'(bus.mem_we), 128'd0);
    check("s1_empty1", 128'(bus.empty), 128'd1);

    // Five back-to-back writes, never completed: fifth is dropped
    for (int i = 0; i < 5; i++) begin
      bus.wr_req  = 1'b1;
      bus.wr_addr = 30'h200 + 30'(i);
      bus.wr_data = 32'h5000_0000 + 32'(i);
      step();
      if (i == 3) begin
        check("full_ready", 128'(bus.wr_ready), 128'd0);
        check("full_count4", 128'(bus.count), 128'd4);
      end
    end
    bus.wr_req = 1'b0;
    check("full_count_after5", 128'(bus.count), 128'd4);
    check("full_head_din", 128'(bus.mem_din), 128'h5000_0000);
    check("full_head_addr", 128'(bus.mem_addr), 128'h80);
    rst = 1'b1;
    #1;
    check_reset("full_rst");
    step();
    rst = 1'b0;
    step();

    // Two writes then a line fill: writes drain first
    push(30'h100, 32'h1111_0001);
    push(30'h205, 32'h2222_0002);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 28'h22;
    expect_write("rw_w0", 30'h100, 32'h1111_0001);
    expect_write("rw_w1", 30'h205, 32'h2222_0002);
    t = 0;
    while (!bus.mem_re && t < 20) begin step(); t++; end
    check("rw_re", 128'(bus.mem_re), 128'd1);
    check("rw_re_addr", 128'(bus.mem_addr), 128'h22);
    check("rw_re_we", 128'(bus.mem_we), 128'd0);
    line = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    bus.mem_dout = line;
    bus.mem_complete = 1'b1;
    step();
    bus.mem_complete = 1'b0;
    bus.rd_req = 1'b0;
    check("rw_valid", 128'(bus.rd_valid), 128'd1);
    check("rw_data", bus.rd_data, line);
    check("rw_re_drop", 128'(bus.mem_re), 128'd0);
    bus.mem_dout = '1;
    step();
    check("rw_valid_pulse", 128'(bus.rd_valid), 128'd0);
    check("rw_data_hold", bus.rd_data, line);

    // Write arriving during a fill with latency 5
    bus.rd_req  = 1'b1;
    bus.rd_addr = 28'h3A;
    step();
    check("wdr_re", 128'(bus.mem_re), 128'd1);
    check("wdr_addr", 128'(bus.mem_addr), 128'h3A);
    push(30'h44, 32'hCAFE_F00D);
    check("wdr_count1", 128'(bus.count), 128'd1);
    check("wdr_re_held", 128'(bus.mem_re), 128'd1);
    check("wdr_no_we", 128'(bus.mem_we), 128'd0);
    step(); step(); step();
    line = 128'hA5A5_5A5A_0000_FFFF_1234_5678_9ABC_DEF0;
    bus.mem_dout = line;
    bus.mem_complete = 1'b1;
    step();
    bus.mem_complete = 1'b0;
    bus.rd_req = 1'b0;
    check("wdr_valid", 128'(bus.rd_valid), 128'd1);
    check("wdr_data", bus.rd_data, line);
    check("wdr_we_during_rdone", 128'(bus.mem_we), 128'd0);
    check("wdr_count_still1", 128'(bus.count), 128'd1);
    expect_write("wdr_w", 30'h44, 32'hCAFE_F00D);
    check("wdr_count0", 128'(bus.count), 128'd0);

    // Pointer wrap: ten writes each completed before the next
    for (int i = 0; i < 10; i++) begin
      wa = 30'h1000 + 30'(i * 5);
      wd = 32'hA5A5_0000 + 32'(i);
      push(wa, wd);
      expect_write("wrap", wa, wd);
      check("wrap_count0", 128'(bus.count), 128'd0);
    end

    // Reset while a write is in flight with three entries held
    push(30'h300, 32'h3000_0000);
    push(30'h301, 32'h3000_0001);
    push(30'h302, 32'h3000_0002);
    check("mid_count3", 128'(bus.count), 128'd3);
    check("mid_we", 128'(bus.mem_we), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    bus.mem_complete = 1'b1;
    step();
    rst = 1'b0;
    step();
    bus.mem_complete = 1'b0;
    check("mid_no_pop_count", 128'(bus.count), 128'd0);
    check("mid_no_we", 128'(bus.mem_we), 128'd0);
    check("mid_ready", 128'(bus.wr_ready), 128'd1);
    push(30'h3FFF_FFFF, 32'h1234_5678);
    expect_write("mid_after", 30'h3FFF_FFFF, 32'h1234_5678);
    check("mid_after_count0", 128'(bus.count), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
